// File: rtl/radar_cfar_pkg.sv
// Shared types and width helpers for the CFAR detector slice.
// Optional greatest-of mode is selected with the CFAR_GO_EN macro.
package radar_cfar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } cfar_state_e;

    localparam int SCALE_FRAC_BITS = 4;

    function automatic int win_len(input int train, input int guard);
        return 2 * (train + guard) + 1;
    endfunction

    function automatic int sum_width(input int data_width, input int train);
        return data_width + $clog2(2 * train);
    endfunction

    // Wide enough for both CUT*2*TRAIN*16 and noise_sum*scale.
    function automatic int prod_width(input int data_width, input int train, input int scale_w);
        return sum_width(data_width, train) + scale_w + SCALE_FRAC_BITS;
    endfunction

endpackage

// File: rtl/cfar_window.sv
// Sliding CFAR window: shift register of the newest samples with
// incrementally maintained lead and lag training sums.
module cfar_window
    import radar_cfar_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TRAIN      = 8,
    parameter int GUARD      = 2
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     shift_en,
    input  logic                                     restart,
    input  logic [DATA_WIDTH-1:0]                    din,
    output logic [DATA_WIDTH-1:0]                    cut,
    output logic [sum_width(DATA_WIDTH, TRAIN)-1:0]  lead_sum,
    output logic [sum_width(DATA_WIDTH, TRAIN)-1:0]  lag_sum
);

    localparam int N  = win_len(TRAIN, GUARD);
    localparam int SW = sum_width(DATA_WIDTH, TRAIN);

    logic [DATA_WIDTH-1:0] w [N];

    // A restart loads the first bin of a frame into an otherwise empty window,
    // so nothing from the previous frame can reach a later output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) w[i] <= '0;
            lead_sum <= '0;
            lag_sum  <= '0;
        end else if (shift_en) begin
            w[0] <= din;
            if (restart) begin
                for (int i = 1; i < N; i++) w[i] <= '0;
                lead_sum <= SW'(din);
                lag_sum  <= '0;
            end else begin
                for (int i = 1; i < N; i++) w[i] <= w[i-1];
                lead_sum <= lead_sum + SW'(din) - SW'(w[TRAIN-1]);
                lag_sum  <= lag_sum + SW'(w[TRAIN+2*GUARD]) - SW'(w[N-1]);
            end
        end
    end

    assign cut = w[TRAIN+GUARD];

endmodule

// File: rtl/cfar_detector.sv
// CFAR detector: frame FSM, bin counter, two-stage window/compare pipeline
// and per-frame hit count. Define CFAR_GO_EN for greatest-of noise estimation.
module cfar_detector
    import radar_cfar_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FFT_SIZE   = 1024,
    parameter int TRAIN      = 8,
    parameter int GUARD      = 2,
    parameter int SCALE_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [DATA_WIDTH-1:0]       mag_in,
    input  logic                        mag_valid,
    input  logic [SCALE_W-1:0]          threshold_scale,
    output logic                        det_valid,
    output logic                        det_hit,
    output logic [$clog2(FFT_SIZE)-1:0] det_range_idx,
    output logic [DATA_WIDTH-1:0]       det_magnitude,
    output logic [DATA_WIDTH-1:0]       det_noise,
    output logic                        frame_done,
    output logic [$clog2(FFT_SIZE):0]   det_count,
    output logic [1:0]                  dbg_state
);

    localparam int IW = $clog2(FFT_SIZE);
    localparam int N  = win_len(TRAIN, GUARD);
    localparam int SW = sum_width(DATA_WIDTH, TRAIN);
    localparam int PW = prod_width(DATA_WIDTH, TRAIN, SCALE_W);
    localparam int TG = TRAIN + GUARD;
    localparam int SH = $clog2(2 * TRAIN) + SCALE_FRAC_BITS;

    cfar_state_e           state, state_nxt;
    logic [IW-1:0]         bin_cnt;
    logic                  accept, emit, restart, last_bin;
    logic [SCALE_W-1:0]    scale_q;

    logic                  s1_valid, s1_last;
    logic [IW-1:0]         s1_idx;
    logic                  det_last;
    logic [IW:0]           hit_cnt;

    logic [DATA_WIDTH-1:0] cut;
    logic [SW-1:0]         lead_sum, lag_sum, noise_sum;
    logic [DATA_WIDTH-1:0] noise_est;
    logic [PW-1:0]         cut_term, noise_term;
    logic                  hit;

    // A sample is taken whenever the detector is enabled, even from IDLE,
    // so the first sample after (re)enable is always bin 0.
    assign accept   = enable & mag_valid;
    assign last_bin = (bin_cnt == IW'(FFT_SIZE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = FILL;
                FILL:    if (accept && bin_cnt == IW'(N - 2)) state_nxt = RUN;
                RUN:     if (accept && last_bin) state_nxt = FILL;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        emit    = accept && (state == RUN);
        restart = accept && (bin_cnt == '0);
    end

    assign dbg_state = 2'(state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_cnt <= '0;
            scale_q <= '0;
        end else begin
            if (!enable)     bin_cnt <= '0;
            else if (accept) bin_cnt <= last_bin ? '0 : bin_cnt + 1'b1;
            if (restart)     scale_q <= threshold_scale;
        end
    end

    cfar_window #(
        .DATA_WIDTH (DATA_WIDTH),
        .TRAIN      (TRAIN),
        .GUARD      (GUARD)
    ) u_window (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (accept),
        .restart  (restart),
        .din      (mag_in),
        .cut      (cut),
        .lead_sum (lead_sum),
        .lag_sum  (lag_sum)
    );

    // Stage 1 bookkeeping travels alongside the window update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= enable & emit;
            s1_idx   <= bin_cnt - IW'(TG);
            s1_last  <= last_bin;
        end
    end

    always_comb begin
        noise_sum = '0;
        noise_est = '0;
`ifdef CFAR_GO_EN
        if (lead_sum > lag_sum) noise_sum = lead_sum;
        else                    noise_sum = lag_sum;
        noise_est = DATA_WIDTH'(noise_sum >> $clog2(TRAIN));
        noise_sum = noise_sum << 1;
`else
        noise_sum = lead_sum + lag_sum;
        noise_est = DATA_WIDTH'(noise_sum >> $clog2(2 * TRAIN));
`endif
        cut_term   = PW'(cut) << SH;
        noise_term = PW'(noise_sum) * PW'(scale_q);
        hit        = cut_term > noise_term;
    end

    // Stage 2: registered decision; dropping enable squashes in-flight results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det_valid     <= 1'b0;
            det_hit       <= 1'b0;
            det_range_idx <= '0;
            det_magnitude <= '0;
            det_noise     <= '0;
            det_last      <= 1'b0;
        end else begin
            det_valid <= enable & s1_valid;
            if (s1_valid) begin
                det_hit       <= hit;
                det_range_idx <= s1_idx;
                det_magnitude <= cut;
                det_noise     <= noise_est;
                det_last      <= s1_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt    <= '0;
            frame_done <= 1'b0;
            det_count  <= '0;
        end else if (!enable) begin
            hit_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= det_valid & det_last;
            if (det_valid) begin
                if (det_last) begin
                    det_count <= hit_cnt + (IW+1)'(det_hit);
                    hit_cnt   <= '0;
                end else begin
                    hit_cnt <= hit_cnt + (IW+1)'(det_hit);
                end
            end
        end
    end

endmodule

// File: tb/tb_cfar_detector.sv
// Directed bench for cfar_detector (FFT_SIZE=32, TRAIN=4, GUARD=2).
module tb_cfar_detector;

    localparam int DW  = 16;
    localparam int FFT = 32;
    localparam int TR  = 4;
    localparam int GD  = 2;
    localparam int SCW = 8;
    localparam int IW  = 5;
    localparam int TG  = TR + GD;
    localparam int NOUT = FFT - 2 * TG;

    logic           clk = 1'b0;
    logic           rst_n, enable, mag_valid;
    logic [DW-1:0]  mag_in;
    logic [SCW-1:0] threshold_scale;
    logic           det_valid, det_hit, frame_done;
    logic [IW-1:0]  det_range_idx;
    logic [DW-1:0]  det_magnitude, det_noise;
    logic [IW:0]    det_count;
    logic [1:0]     dbg_state;

    cfar_detector #(
        .DATA_WIDTH (DW),
        .FFT_SIZE   (FFT),
        .TRAIN      (TR),
        .GUARD      (GD),
        .SCALE_W    (SCW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .mag_in          (mag_in),
        .mag_valid       (mag_valid),
        .threshold_scale (threshold_scale),
        .det_valid       (det_valid),
        .det_hit         (det_hit),
        .det_range_idx   (det_range_idx),
        .det_magnitude   (det_magnitude),
        .det_noise       (det_noise),
        .frame_done      (frame_done),
        .det_count       (det_count),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    int samp  [2][FFT];
    int scl   [2][FFT];
    int stamp [2][FFT];

    int out_idx[$], out_hit[$], out_mag[$], out_noise[$], out_cyc[$];
    int fd_cnt[$], fd_cyc[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (det_valid) begin
                out_idx.push_back(int'(det_range_idx));
                out_hit.push_back(int'(det_hit));
                out_mag.push_back(int'(det_magnitude));
                out_noise.push_back(int'(det_noise));
                out_cyc.push_back(cyc);
            end
            if (frame_done) begin
                fd_cnt.push_back(int'(det_count));
                fd_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic build_frame(input int f, input int bg, input int sb, input int sv,
                               input int s0, input int s1, input int chg);
        for (int b = 0; b < FFT; b++) begin
            samp[f][b] = (b == sb) ? sv : bg;
            scl[f][b]  = (b < chg) ? s0 : s1;
        end
    endtask

    task automatic drive_bins(input int f, input int first, input int last);
        for (int b = first; b <= last; b++) begin
            @(posedge clk); #1;
            enable          = 1'b1;
            mag_valid       = 1'b1;
            mag_in          = DW'(samp[f][b]);
            threshold_scale = SCW'(scl[f][b]);
            stamp[f][b]     = cyc;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            mag_valid = 1'b0;
        end
    endtask

    task automatic flush_queues();
        out_idx.delete(); out_hit.delete(); out_mag.delete();
        out_noise.delete(); out_cyc.delete(); fd_cnt.delete(); fd_cyc.delete();
    endtask

    // Reference: direct window sums over the stored frame, scale from bin 0.
    task automatic verify_frame(input int f, input int n_out, input int exp_count,
                                input int probe, input int p_noise, input int p_hit);
        int seen;
        int lead, lag, ns, ne, eh, mx;
        int a_idx, a_hit, a_mag, a_noise, a_cyc;
        int c;
        seen = 0;
        for (int k = 0; k < n_out; k++) begin
            c = TG + k;
            if (out_idx.size() == 0) begin
                check("output_missing", k, n_out);
                break;
            end
            lead = 0;
            lag  = 0;
            for (int t = GD + 1; t <= GD + TR; t++) begin
                lead += samp[f][c+t];
                lag  += samp[f][c-t];
            end
`ifdef CFAR_GO_EN
            mx = (lead > lag) ? lead : lag;
            ns = 2 * mx;
            ne = mx / TR;
`else
            mx = 0;
            ns = lead + lag;
            ne = ns / (2 * TR);
`endif
            eh = (samp[f][c] * 2 * TR * 16 > ns * scl[f][0]) ? 1 : 0;
            a_idx   = out_idx.pop_front();
            a_hit   = out_hit.pop_front();
            a_mag   = out_mag.pop_front();
            a_noise = out_noise.pop_front();
            a_cyc   = out_cyc.pop_front();
            check("range_idx", a_idx, c);
            check("latency", a_cyc, stamp[f][c+TG] + 2);
            check("magnitude", a_mag, samp[f][c]);
            check("noise", a_noise, ne);
            check("hit", a_hit, eh);
            if (c == probe) begin
                seen = 1;
                check("probe_noise", a_noise, p_noise);
                check("probe_hit", a_hit, p_hit);
            end
        end
        check("probe_seen", seen, 1);
        if (exp_count < 0) begin
            check("no_frame_done", fd_cnt.size(), 0);
        end else if (fd_cnt.size() == 0) begin
            check("frame_done_missing", 0, 1);
        end else begin
            check("det_count", fd_cnt.pop_front(), exp_count);
            check("frame_done_cycle", fd_cyc.pop_front(), stamp[f][FFT-1] + 3);
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int bg;
        int spike_bin;
        int spike_val;
        int scale;
        int probe;
        int exp_noise;
        int exp_hit;
        int exp_count;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{bg: 100, spike_bin: -1, spike_val: 0,    scale: 'h30, probe: 16, exp_noise: 100, exp_hit: 0, exp_count: 0};
        vecs[1] = '{bg: 100, spike_bin: 16, spike_val: 400,  scale: 'h30, probe: 16, exp_noise: 100, exp_hit: 1, exp_count: 1};
        vecs[2] = '{bg: 100, spike_bin: 16, spike_val: 250,  scale: 'h30, probe: 16, exp_noise: 100, exp_hit: 0, exp_count: 0};
        vecs[3] = '{bg: 100, spike_bin: 16, spike_val: 300,  scale: 'h30, probe: 16, exp_noise: 100, exp_hit: 0, exp_count: 0};
        // Spike at bin 3 sits in the lag window of CUTs 6..9: (7*100+1000)/8 = 212.
        vecs[4] = '{bg: 100, spike_bin: 3,  spike_val: 1000, scale: 'h30, probe: 7,  exp_noise: 212, exp_hit: 0, exp_count: 0};

        rst_n = 1'b0;
        enable = 1'b0;
        mag_valid = 1'b0;
        mag_in = '0;
        threshold_scale = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_det_valid", det_valid, 0);
        check("rst_det_hit", det_hit, 0);
        check("rst_range_idx", det_range_idx, 0);
        check("rst_magnitude", det_magnitude, 0);
        check("rst_noise", det_noise, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_det_count", det_count, 0);
        check("rst_state", dbg_state, 0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        enable = 1'b1;
        idle_cycles(2);

        // Table-driven single frames.
        for (int v = 0; v < 5; v++) begin
            flush_queues();
            build_frame(0, vecs[v].bg, vecs[v].spike_bin, vecs[v].spike_val,
                        vecs[v].scale, vecs[v].scale, FFT);
            drive_bins(0, 0, FFT - 1);
            idle_cycles(6);
            check("outputs_per_frame", out_idx.size(), NOUT);
            verify_frame(0, NOUT, vecs[v].exp_count, vecs[v].probe,
                         vecs[v].exp_noise, vecs[v].exp_hit);
        end

        // Back-to-back frames; scale changes at bin 10 of the first frame.
        flush_queues();
        build_frame(0, 100, 16, 300, 'h30, 'h10, 10);
        build_frame(1, 100, 16, 300, 'h10, 'h10, FFT);
        drive_bins(0, 0, FFT - 1);
        drive_bins(1, 0, FFT - 1);
        idle_cycles(6);
        check("outputs_two_frames", out_idx.size(), 2 * NOUT);
        check("frame_dones_two_frames", fd_cnt.size(), 2);
        verify_frame(0, NOUT, 0, 16, 100, 0);
        verify_frame(1, NOUT, 1, 16, 100, 1);

        // Abort at bin 20: only CUTs 6..12 make it out, no frame_done.
        flush_queues();
        build_frame(0, 100, 16, 400, 'h30, 'h30, FFT);
        drive_bins(0, 0, 19);
        repeat (4) begin
            @(posedge clk); #1;
            enable = 1'b0;
            mag_valid = 1'b1;
            mag_in = DW'(5000);
        end
        @(negedge clk);
        check("abort_state_idle", dbg_state, 0);
        check("abort_outputs", out_idx.size(), 7);
        verify_frame(0, 7, -1, 6, 100, 0);

        @(posedge clk); #1;
        enable = 1'b1;
        mag_valid = 1'b0;
        flush_queues();
        drive_bins(0, 0, FFT - 1);
        idle_cycles(6);
        check("reenable_outputs", out_idx.size(), NOUT);
        verify_frame(0, NOUT, 1, 16, 100, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
